// File: rtl/conf_arbiter.sv
// Two-requester arbiter onto a config-register port: grant in T, conf access in T+1, rvalid in T+2.
// Default arbitration is fixed priority (m0 wins); define CONF_ARB_RR_EN for round-robin.
module conf_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [3:0]    m0_wen,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_wen,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          conf_en,
  output logic [3:0]    conf_wen,
  output logic [DW-1:0] conf_addr,
  output logic [DW-1:0] conf_wdata,
  input  logic [DW-1:0] conf_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          conf_en_q, conf_en_d;
  logic [3:0]    conf_wen_q, conf_wen_d;
  logic [DW-1:0] conf_addr_q, conf_addr_d;
  logic [DW-1:0] conf_wdata_q, conf_wdata_d;
  logic          id_q, id_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
`ifdef CONF_ARB_RR_EN
  logic          last_q, last_d;
`endif

  logic win_id;
  logic grant;

  always_comb begin
`ifdef CONF_ARB_RR_EN
    // On a tie, favour whichever requester did not win last time.
    if (m0_req && m1_req) win_id = ~last_q;
    else                  win_id = m1_req;
`else
    win_id = ~m0_req;
`endif
  end

  assign grant  = (state_q == IDLE) && (m0_req || m1_req);
  assign m0_gnt = grant && !win_id;
  assign m1_gnt = grant && win_id;

  always_comb begin
    state_d      = state_q;
    conf_en_d    = 1'b0;
    conf_wen_d   = 4'h0;
    conf_addr_d  = conf_addr_q;
    conf_wdata_d = conf_wdata_q;
    id_d         = id_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef CONF_ARB_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = ACCESS;
          conf_en_d    = 1'b1;
          conf_wen_d   = win_id ? m1_wen   : m0_wen;
          conf_addr_d  = win_id ? m1_addr  : m0_addr;
          conf_wdata_d = win_id ? m1_wdata : m0_wdata;
          id_d         = win_id;
`ifdef CONF_ARB_RR_EN
          last_d       = win_id;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Read data is captured for writes too; the requester may ignore it.
        if (id_q) begin
          rdata1_d  = conf_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = conf_rdata;
          rvalid0_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      conf_en_q    <= 1'b0;
      conf_wen_q   <= 4'h0;
      conf_addr_q  <= '0;
      conf_wdata_q <= '0;
      id_q         <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef CONF_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      conf_en_q    <= conf_en_d;
      conf_wen_q   <= conf_wen_d;
      conf_addr_q  <= conf_addr_d;
      conf_wdata_q <= conf_wdata_d;
      id_q         <= id_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef CONF_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign conf_en    = conf_en_q;
  assign conf_wen   = conf_wen_q;
  assign conf_addr  = conf_addr_q;
  assign conf_wdata = conf_wdata_q;
  assign m0_rvalid  = rvalid0_q;
  assign m1_rvalid  = rvalid1_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_conf_arbiter.sv
// Bench for conf_arbiter: vector table, directed corner sequences, then random traffic vs a cycle-count model.
module tb_conf_arbiter;
  localparam int DW = 32;
`ifdef CONF_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [3:0]    m0_wen, m1_wen;
  logic [DW-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          conf_en;
  logic [3:0]    conf_wen;
  logic [DW-1:0] conf_addr, conf_wdata, conf_rdata;

  always #5 clk = ~clk;

  conf_arbiter #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          r0, r1;
    logic [3:0]    w0, w1;
    logic [DW-1:0] a0, a1, d0, d1, rd;
    logic          win_fp, win_rr;
  } vec_t;

  vec_t tbl [6];
  vec_t v;
  logic exp_w;

  // random-phase model state
  logic          hold [2];
  logic          gprev [2];
  logic [3:0]    rw [2];
  logic [DW-1:0] ra [2];
  logic [DW-1:0] rdw [2];
  int            next_free, acc_c, resp_c;
  logic          acc_id, last_m, take, win, e0, e1;
  logic [3:0]    lat_wen;
  logic [DW-1:0] lat_addr, lat_wdata, captured;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'hF, 4'h0, 32'h0000_f000, 32'h0, 32'h0000_A5A5, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0000_f000, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 4'h1, 4'h2, 32'h10, 32'h20, 32'h1111, 32'h2222, 32'hAAAA_0003, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'h0, 4'hC, 32'h30, 32'h40, 32'h3333, 32'h4444, 32'hBBBB_0004, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'h0, 4'h3, 32'h0, 32'h50, 32'h0, 32'h5555, 32'hCCCC_0005, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 4'h8, 4'h0, 32'h60, 32'h70, 32'h6666, 32'h7777, 32'hDDDD_0006, 1'b0, 1'b0};

    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_wen = 4'h0; m1_wen = 4'h0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; conf_rdata = '0;
    #1;
    chk1("rst_conf_en", conf_en, 1'b0);
    chk4("rst_conf_wen", conf_wen, 4'h0);
    chkw("rst_conf_addr", conf_addr, '0);
    chkw("rst_conf_wdata", conf_wdata, '0);
    chk1("rst_rvalid", m0_rvalid | m1_rvalid, 1'b0);
    chkw("rst_m0_rdata", m0_rdata, '0);
    chkw("rst_m1_rdata", m1_rdata, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Vector table: one isolated transfer per entry.
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      exp_w = RR ? v.win_rr : v.win_fp;
      @(negedge clk);
      m0_req = v.r0; m0_wen = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_wen = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
      conf_rdata = v.rd;
      #1;
      chk1("tbl_m0_gnt", m0_gnt, !exp_w);
      chk1("tbl_m1_gnt", m1_gnt, exp_w);
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;
      #1;
      chk1("tbl_acc_conf_en", conf_en, 1'b1);
      chk4("tbl_acc_conf_wen", conf_wen, exp_w ? v.w1 : v.w0);
      chkw("tbl_acc_conf_addr", conf_addr, exp_w ? v.a1 : v.a0);
      chkw("tbl_acc_conf_wdata", conf_wdata, exp_w ? v.d1 : v.d0);
      chk1("tbl_acc_no_gnt", m0_gnt | m1_gnt, 1'b0);
      chk1("tbl_acc_no_rvalid", m0_rvalid | m1_rvalid, 1'b0);
      @(negedge clk);
      #1;
      chk1("tbl_resp_m0_rvalid", m0_rvalid, !exp_w);
      chk1("tbl_resp_m1_rvalid", m1_rvalid, exp_w);
      chkw("tbl_resp_rdata", exp_w ? m1_rdata : m0_rdata, v.rd);
      chk1("tbl_resp_conf_en", conf_en, 1'b0);
      chk4("tbl_resp_conf_wen", conf_wen, 4'h0);
      chkw("tbl_resp_conf_addr_hold", conf_addr, exp_w ? v.a1 : v.a0);
    end

    // m1 request arriving during an m0 transfer waits for the next IDLE cycle.
    @(negedge clk);
    m0_req = 1'b1; m0_wen = 4'h3; m0_addr = 32'h100; m0_wdata = 32'h0101;
    #1;
    chk1("late_m0_gnt", m0_gnt, 1'b1);
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_wen = 4'h0; m1_addr = 32'h200; m1_wdata = 32'h0202;
    conf_rdata = 32'h5EED_0001;
    #1;
    chk1("late_acc_m1_gnt", m1_gnt, 1'b0);
    chk1("late_acc_m0_gnt", m0_gnt, 1'b0);
    chk1("late_acc_conf_en", conf_en, 1'b1);
    @(negedge clk);
    #1;
    chk1("late_resp_m1_gnt", m1_gnt, 1'b0);
    chk1("late_resp_m0_rvalid", m0_rvalid, 1'b1);
    chkw("late_resp_m0_rdata", m0_rdata, 32'h5EED_0001);
    @(negedge clk);
    conf_rdata = 32'h5EED_0002;
    #1;
    chk1("late_t3_m1_gnt", m1_gnt, 1'b1);
    @(negedge clk);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_wen = 4'hF; m0_addr = 32'hDEAD; m0_wdata = 32'hBEEF;
    #1;
    chk1("late_m1_acc_conf_en", conf_en, 1'b1);
    chkw("late_m1_acc_conf_addr", conf_addr, 32'h200);
    chk4("late_m1_acc_conf_wen", conf_wen, 4'h0);
    chk1("drop_acc_m0_gnt", m0_gnt, 1'b0);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk1("late_m1_rvalid", m1_rvalid, 1'b1);
    chkw("late_m1_rdata", m1_rdata, 32'h5EED_0002);
    chkw("m0_rdata_hold", m0_rdata, 32'h5EED_0001);
    @(negedge clk);
    #1;
    chk1("drop_idle_no_gnt", m0_gnt | m1_gnt, 1'b0);
    @(negedge clk);
    #1;
    chk1("drop_no_conf_en", conf_en, 1'b0);
    chkw("drop_conf_addr_hold", conf_addr, 32'h200);
    chk1("drop_no_rvalid", m0_rvalid | m1_rvalid, 1'b0);

    // Reset asserted mid-ACCESS aborts the transfer.
    @(negedge clk);
    m1_req = 1'b1; m1_wen = 4'hF; m1_addr = 32'h300; m1_wdata = 32'h0303;
    #1;
    chk1("rstacc_m1_gnt", m1_gnt, 1'b1);
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    chk1("rstacc_conf_en_before", conf_en, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rstacc_conf_en_after", conf_en, 1'b0);
    chk4("rstacc_conf_wen_after", conf_wen, 4'h0);
    chkw("rstacc_conf_addr_after", conf_addr, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk1("rstacc_no_rvalid", m0_rvalid | m1_rvalid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Continuous contention for four accesses, starting right after reset.
    @(negedge clk);
    m0_req = 1'b1; m0_wen = 4'h1; m0_addr = 32'hA0; m0_wdata = 32'hA000;
    m1_req = 1'b1; m1_wen = 4'h2; m1_addr = 32'hB0; m1_wdata = 32'hB000;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      conf_rdata = 32'hF00D_0000 + k;
      #1;
      chk1("cont_m0_gnt", m0_gnt, RR ? (k % 2 == 0) : 1'b1);
      chk1("cont_m1_gnt", m1_gnt, RR ? (k % 2 == 1) : 1'b0);
      @(negedge clk);
      #1;
      chk1("cont_acc_no_gnt", m0_gnt | m1_gnt, 1'b0);
      @(negedge clk);
      #1;
      chk1("cont_resp_no_gnt", m0_gnt | m1_gnt, 1'b0);
      chkw("cont_resp_rdata", (RR && (k % 2 == 1)) ? m1_rdata : m0_rdata, 32'hF00D_0000 + k);
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;

    // Random traffic against a cycle-count model of the arbiter.
    last_m    = RR ? 1'b1 : 1'b0;
    lat_wen   = 4'h0;
    lat_addr  = RR ? 32'hB0 : 32'hA0;
    lat_wdata = RR ? 32'hB000 : 32'hA000;
    captured  = '0;
    acc_id    = 1'b0;
    next_free = 0; acc_c = -10; resp_c = -10;
    for (int i = 0; i < 2; i++) begin
      hold[i] = 1'b0; gprev[i] = 1'b0; rw[i] = 4'h0; ra[i] = '0; rdw[i] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (hold[i] && gprev[i]) hold[i] = 1'b0;
        if (!hold[i] && $urandom_range(2) == 0) begin
          hold[i] = 1'b1;
          rw[i]   = 4'($urandom_range(15));
          ra[i]   = $urandom;
          rdw[i]  = $urandom;
        end
      end
      m0_req = hold[0]; m0_wen = rw[0]; m0_addr = ra[0]; m0_wdata = rdw[0];
      m1_req = hold[1]; m1_wen = rw[1]; m1_addr = ra[1]; m1_wdata = rdw[1];
      conf_rdata = $urandom;
      #1;
      take = (c >= next_free) && (hold[0] || hold[1]);
      if (RR) win = (hold[0] && hold[1]) ? !last_m : hold[1];
      else    win = !hold[0];
      e0 = take && !win;
      e1 = take && win;
      chk1("rnd_m0_gnt", m0_gnt, e0);
      chk1("rnd_m1_gnt", m1_gnt, e1);
      chk1("rnd_conf_en", conf_en, c == acc_c);
      chk4("rnd_conf_wen", conf_wen, (c == acc_c) ? lat_wen : 4'h0);
      chkw("rnd_conf_addr", conf_addr, lat_addr);
      chkw("rnd_conf_wdata", conf_wdata, lat_wdata);
      chk1("rnd_m0_rvalid", m0_rvalid, (c == resp_c) && !acc_id);
      chk1("rnd_m1_rvalid", m1_rvalid, (c == resp_c) && acc_id);
      if (c == resp_c) chkw("rnd_rdata", acc_id ? m1_rdata : m0_rdata, captured);
      if (c == acc_c) captured = conf_rdata;
      if (take) begin
        acc_c     = c + 1;
        resp_c    = c + 2;
        next_free = c + 3;
        acc_id    = win;
        last_m    = win;
        lat_wen   = rw[win];
        lat_addr  = ra[win];
        lat_wdata = rdw[win];
      end
      gprev[0] = e0;
      gprev[1] = e1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
